mc_cpu_core: RTL and testbench
==============================

// Module: mc_cpu_core
// PURPOSE
//  Parametrised multi-cycle CPU core: FSM-sequenced fetch/decode/execute/mem/writeback.
//  8-entry register file, internal ALU, PC, HALT/run control, illegal-opcode flag.
//  Instruction and data memories sit outside the core, each on a req/ack port.
//  Sits between the system memories and the debug/testbench top.
// PARAMETERS
//  DATA_W   16  datapath and register width (>=16); immediates sign-extend to DATA_W
//  PC_W     12  PC / imem address width; PC wraps modulo 2^PC_W
//  DADDR_W  8   dmem address width = low DADDR_W bits of the effective address
// PORTS
//  clk         in   1        clock
//  rst_n       in   1        asynchronous, active-low reset
//  run         in   1        leave IDLE/HALT; ignored in any other state
//  imem_req    out  1        instruction fetch request, held until ack
//  imem_addr   out  PC_W     fetch address (= PC)
//  imem_ack    in   1        rdata valid this cycle; ignored while req=0
//  imem_rdata  in   16       instruction word
//  dmem_req    out  1        data access request, held until ack
//  dmem_we     out  1        1 = store, 0 = load
//  dmem_addr   out  DADDR_W  effective address
//  dmem_wdata  out  DATA_W   store data
//  dmem_rdata  in   DATA_W   load data, valid with ack
//  dmem_ack    in   1        access complete; ignored while req=0
//  halted      out  1        1 in IDLE and HALT
//  illegal     out  1        1-cycle pulse on an undefined opcode
//  dbg_sel     in   3        register select for debug read
//  dbg_data    out  DATA_W   combinational read of gr[dbg_sel]
// BEHAVIOUR
//  Reset: state=IDLE, PC=0, all gr=0, IR=0, all req/we=0, halted=1, illegal=0.
//  Format: op[15:12] rd[11:9] rs[8:6] rt[5:3]; imm6=[5:0] sext; imm9=[8:0] zext; imm12=[11:0].
//  ALU ops (rd <= rs op rt): 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 SHL (shift amount rt[3:0]).
//  Other ops:
//   - 0 NOP; 7 ADDI rd=rs+imm6; 8 LI rd=imm9
//   - 9 LD rd=mem[rs+imm6]; A ST mem[rs+imm6]=rd
//   - B BEQ: if rd==rs then PC=PC+1+imm6; C JMP: PC=imm12; F HALT
//   - D, E: illegal -> pulse illegal in EXEC, then execute as NOP
//  Arithmetic is modulo 2^DATA_W, with no flags. gr0 always reads 0; writes to it are dropped.
//  FSM: IDLE -run-> FETCH -ack-> DECODE -> EXEC -> {MEM (LD/ST) | WB | FETCH | HALT}.
//   FETCH: imem_req=1, imem_addr=PC; IR latched on the ack cycle.
//   DECODE: operands A=gr[rs], B=gr[rt], or gr[rd] for ST/BEQ.
//   EXEC: ALU/address result latched. PC updates here, to PC+1 or the branch/jump target.
//   MEM: dmem_req=1; address/wdata/we held stable until ack; LD data latched on ack.
//   WB: gr[rd] written, then FETCH. NOP/ST/BEQ/JMP/illegal skip WB.
//   HALT: halted=1; a run pulse resumes FETCH at PC (already the HALT address + 1).
//  Latency with zero-wait ack (ack in the first req cycle):
//   - ALU/LI/ADDI/LD: 4 cycles + 1 for LD
//   - NOP/BEQ/JMP/ST: 3 cycles + 1 for ST
//  Each wait cycle adds 1. req never drops before ack. At most one outstanding access.
//  Edges: PC=2^PC_W-1 increments to 0; BEQ target wraps identically.
//  run held high in HALT resumes once; HALT executes again if re-fetched.
//  ack asserted without req is ignored.
//  rst_n low mid-access: req drops asynchronously and the transaction is abandoned.
//  dbg_data has no side effects and does not stall the core.
// STRUCTURE
//  Shared package/header: DATA_W/PC_W defaults, opcode localparams OP_ADD..OP_HALT,
//  FSM state encodings S_IDLE..S_HALT, instruction field bit positions.
//  One sub-module: mc_alu (comb.; a, b, op -> y, DATA_W param). Regfile and FSM stay in the core.
// TESTING
//  - Reset then run; LI r1,5; LI r2,3; ADD r3,r1,r2; HALT -> r3=8, halted=1, PC=4.
//  - SUB r4,r2,r1 (r1=5, r2=3) -> r4=0xFFFE (DATA_W=16); LI r0,7 -> dbg r0 still 0.
//  - ST r1,[r2+1] (r1=5, r2=3) then LD r5,[r2+1]; dmem ack delayed 3 cycles
//      -> dmem_addr=4 held stable, r5=5, 1+3 extra cycles over the baseline.
//  - BEQ r1,r1,-1 at PC=10 -> PC=10 loop; JMP 0xFFF then NOP at 0xFFF -> next fetch at PC=0.
//  - Opcode 0xD -> illegal high exactly one cycle, registers unchanged, next fetch at PC+1.
//  - rst_n low while imem_req=1 waiting -> req=0 same cycle, all regs 0, IDLE, halted=1.

Source files
------------

// File: rtl/mc_cpu_pkg.sv
// mc_cpu_pkg: shared widths, opcodes, instruction field positions and FSM states for mc_cpu_core
package mc_cpu_pkg;
   localparam int DATA_W_DEF  = 16;
   localparam int PC_W_DEF    = 12;
   localparam int DADDR_W_DEF = 8;
   localparam logic [3:0] OP_NOP   = 4'h0;
   localparam logic [3:0] OP_ADD   = 4'h1;
   localparam logic [3:0] OP_SUB   = 4'h2;
   localparam logic [3:0] OP_AND   = 4'h3;
   localparam logic [3:0] OP_OR    = 4'h4;
   localparam logic [3:0] OP_XOR   = 4'h5;
   localparam logic [3:0] OP_SHL   = 4'h6;
   localparam logic [3:0] OP_ADDI  = 4'h7;
   localparam logic [3:0] OP_LI    = 4'h8;
   localparam logic [3:0] OP_LD    = 4'h9;
   localparam logic [3:0] OP_ST    = 4'hA;
   localparam logic [3:0] OP_BEQ   = 4'hB;
   localparam logic [3:0] OP_JMP   = 4'hC;
   localparam logic [3:0] OP_ILL_D = 4'hD;
   localparam logic [3:0] OP_ILL_E = 4'hE;
   localparam logic [3:0] OP_HALT  = 4'hF;
   localparam int OP_HI = 15;
   localparam int OP_LO = 12;
   localparam int RD_HI = 11;
   localparam int RD_LO = 9;
   localparam int RS_HI = 8;
   localparam int RS_LO = 6;
   localparam int RT_HI = 5;
   localparam int RT_LO = 3;
   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;
   function automatic logic is_alu(input logic [3:0] op);
      return op >= OP_ADD && op <= OP_SHL;
   endfunction
endpackage

// File: rtl/mc_cpu_core_alu.sv
// mc_alu: combinational ALU, y = a op b modulo 2^DATA_W (non-ALU opcodes add)
module mc_alu
   import mc_cpu_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [3:0]        op,
   output logic [DATA_W-1:0] y
);
   always_comb
      y = op == OP_SUB ? a - b :
          op == OP_AND ? a & b :
          op == OP_OR  ? a | b :
          op == OP_XOR ? a ^ b :
          op == OP_SHL ? a << b[3:0] :
                         a + b;
endmodule

// File: rtl/mc_cpu_core.sv
// mc_cpu_core: multi-cycle fetch/decode/exec/mem/wb CPU with 8-entry register file and req/ack memories
module mc_cpu_core
   import mc_cpu_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int PC_W    = PC_W_DEF,
   parameter int DADDR_W = DADDR_W_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               run,
   output logic               imem_req,
   output logic [PC_W-1:0]    imem_addr,
   input  logic               imem_ack,
   input  logic [15:0]        imem_rdata,
   output logic               dmem_req,
   output logic               dmem_we,
   output logic [DADDR_W-1:0] dmem_addr,
   output logic [DATA_W-1:0]  dmem_wdata,
   input  logic [DATA_W-1:0]  dmem_rdata,
   input  logic               dmem_ack,
   output logic               halted,
   output logic               illegal,
   input  logic [2:0]         dbg_sel,
   output logic [DATA_W-1:0]  dbg_data
);
   state_t              state_q, state_d;
   logic [PC_W-1:0]     pc_q, pc_d;
   logic [15:0]         ir_q, ir_d;
   logic [DATA_W-1:0]   a_q, a_d, b_q, b_d, res_q, res_d;
   logic [DATA_W-1:0]   gr_q [8];
   logic [DATA_W-1:0]   gr_d [8];
   logic [3:0]          op, alu_op;
   logic [2:0]          rd, rs, rt;
   logic [DATA_W-1:0]   imm6_x, alu_b, alu_y;
   logic [PC_W-1:0]     imm6_pc;

   always_comb begin
      op      = ir_q[OP_HI:OP_LO];
      rd      = ir_q[RD_HI:RD_LO];
      rs      = ir_q[RS_HI:RS_LO];
      rt      = ir_q[RT_HI:RT_LO];
      imm6_x  = {{(DATA_W-6){ir_q[5]}}, ir_q[5:0]};
      imm6_pc = {{(PC_W-6){ir_q[5]}}, ir_q[5:0]};
      alu_b   = is_alu(op) ? b_q : imm6_x;
      alu_op  = is_alu(op) ? op : OP_ADD;
   end

   mc_alu #(.DATA_W(DATA_W)) u_alu (.a(a_q), .b(alu_b), .op(alu_op), .y(alu_y));

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      gr_d    = gr_q;
      unique case (state_q)
         S_IDLE, S_HALT: state_d = run ? S_FETCH : state_q;
         S_FETCH: begin
            ir_d    = imem_ack ? imem_rdata : ir_q;
            state_d = imem_ack ? S_DECODE : S_FETCH;
         end
         S_DECODE: begin
            a_d     = gr_q[rs];
            b_d     = (op == OP_ST || op == OP_BEQ) ? gr_q[rd] : gr_q[rt];
            state_d = S_EXEC;
         end
         S_EXEC: begin
            res_d   = op == OP_LI ? {{(DATA_W-9){1'b0}}, ir_q[8:0]} : alu_y;
            pc_d    = op == OP_JMP ? PC_W'(ir_q[11:0]) :
                      (op == OP_BEQ && a_q == b_q) ? pc_q + imm6_pc + PC_W'(1) : pc_q + PC_W'(1);
            state_d = (op == OP_LD || op == OP_ST) ? S_MEM :
                      (is_alu(op) || op == OP_ADDI || op == OP_LI) ? S_WB :
                      op == OP_HALT ? S_HALT : S_FETCH;
         end
         S_MEM: begin
            res_d   = (dmem_ack && op == OP_LD) ? dmem_rdata : res_q;
            state_d = !dmem_ack ? S_MEM : op == OP_LD ? S_WB : S_FETCH;
         end
         S_WB: begin
            if (rd != 3'd0) gr_d[rd] = res_q;
            state_d = S_FETCH;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      imem_req   = state_q == S_FETCH;
      imem_addr  = pc_q;
      dmem_req   = state_q == S_MEM;
      dmem_we    = state_q == S_MEM && op == OP_ST;
      dmem_addr  = res_q[DADDR_W-1:0];
      dmem_wdata = b_q;
      halted     = state_q == S_IDLE || state_q == S_HALT;
      illegal    = state_q == S_EXEC && (op == OP_ILL_D || op == OP_ILL_E);
      dbg_data   = gr_q[dbg_sel];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         pc_q    <= '0;
         ir_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         gr_q    <= '{default: '0};
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         gr_q    <= gr_d;
      end
   end
endmodule

// File: tb/tb_mc_cpu_core.sv
// tb_mc_cpu_core: directed programs with a fetch/data-access scoreboard checked by a negedge monitor
module tb_mc_cpu_core;
   logic        clk = 0, rst_n = 1, run = 0;
   logic        imem_req, imem_ack = 0, dmem_req, dmem_we, dmem_ack = 0, halted, illegal;
   logic [11:0] imem_addr;
   logic [15:0] imem_rdata = 0, dmem_wdata, dmem_rdata = 0, dbg_data;
   logic [7:0]  dmem_addr;
   logic [2:0]  dbg_sel = 0;
   int          total = 0, bad = 0, cyc = 0, ill_cnt = 0, iwait = 0, dwait = 0, icnt = 0, dcnt = 0;
   int          base, ill0, e_pc;
   bit          spurious = 0, ireq_p = 0, dreq_p = 0, cur_we;
   logic [7:0]  cur_da;
   logic [15:0] cur_dw;
   logic [15:0] imem [4096];
   logic [15:0] dmem [256];
   int          exp_pc[$];
   bit          exp_we[$];
   logic [7:0]  exp_da[$];
   logic [15:0] exp_dw[$];
   int          fetch_t[$];

   mc_cpu_core dut (
      .clk(clk), .rst_n(rst_n), .run(run),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
      .halted(halted), .illegal(illegal), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic rchk(input string nm, input int r, input logic [15:0] exp);
      dbg_sel = 3'(r);
      #1 chk(nm, 32'(dbg_data), 32'(exp));
   endtask

   task automatic dchk(input string nm, input int i, input int exp);
      if (fetch_t.size() > i + 1) chk(nm, fetch_t[i+1] - fetch_t[i], exp);
      else chk({nm, "_missing"}, 32'hdead, exp);
   endtask

   task automatic pulse_run();
      @(negedge clk) run = 1;
      @(negedge clk) run = 0;
   endtask

   task automatic run_prog(input string nm);
      pulse_run();
      for (int i = 0; i < 400 && !halted; i++) @(negedge clk);
      chk({"halt_", nm}, 32'(halted), 1);
   endtask

   // memory responders: ack after iwait/dwait request cycles, data valid with ack
   always @(negedge clk) begin
      if (imem_req) begin
         imem_ack   = icnt == iwait;
         imem_rdata = imem[imem_addr];
         icnt++;
      end else begin
         imem_ack = spurious;
         icnt     = 0;
      end
      if (dmem_req) begin
         dmem_ack   = dcnt == dwait;
         dmem_rdata = dmem[dmem_addr];
         if (dmem_ack && dmem_we) dmem[dmem_addr] = dmem_wdata;
         dcnt++;
      end else begin
         dmem_ack = spurious;
         dcnt     = 0;
      end
   end

   always @(negedge clk) begin
      if (imem_req && !ireq_p) begin
         fetch_t.push_back(cyc);
         if (exp_pc.size() == 0) chk("fetch_unexpected", 32'(imem_addr), 32'hffff_ffff);
         else begin
            e_pc = exp_pc.pop_front();
            chk("fetch_addr", 32'(imem_addr), e_pc);
         end
      end
      ireq_p = imem_req;
      if (dmem_req && !dreq_p) begin
         if (exp_we.size() == 0) chk("dmem_unexpected", 32'(dmem_addr), 32'hffff_ffff);
         else begin
            cur_we = exp_we.pop_front();
            cur_da = exp_da.pop_front();
            cur_dw = exp_dw.pop_front();
            chk("dmem_we", 32'(dmem_we), 32'(cur_we));
            if (cur_we) chk("dmem_wdata", 32'(dmem_wdata), 32'(cur_dw));
         end
      end
      if (dmem_req) chk("dmem_addr", 32'(dmem_addr), 32'(cur_da));
      dreq_p = dmem_req;
      if (illegal) ill_cnt++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 4096; i++) imem[i] = 16'h0000;
      for (int i = 0; i < 256; i++) dmem[i] = 16'h0000;
      imem[0]  = 16'h8205;  // LI r1,5
      imem[1]  = 16'h8403;  // LI r2,3
      imem[2]  = 16'h1650;  // ADD r3,r1,r2
      imem[3]  = 16'hF000;  // HALT
      imem[4]  = 16'h2888;  // SUB r4,r2,r1
      imem[5]  = 16'h8007;  // LI r0,7
      imem[6]  = 16'hA281;  // ST r1,[r2+1]
      imem[7]  = 16'h9A81;  // LD r5,[r2+1]
      imem[8]  = 16'hF000;  // HALT
      imem[9]  = 16'h0000;  // NOP
      imem[10] = 16'hB27F;  // BEQ r1,r1,-1
      #2 rst_n = 0;
      repeat (2) @(negedge clk);
      chk("rst_halted", 32'(halted), 1);
      chk("rst_imem_req", 32'(imem_req), 0);
      chk("rst_dmem_req", 32'(dmem_req), 0);
      chk("rst_illegal", 32'(illegal), 0);
      for (int r = 0; r < 8; r++) rchk("rst_reg", r, 16'h0);
      rst_n = 1;
      spurious = 1;
      repeat (3) @(negedge clk);
      spurious = 0;
      @(negedge clk);
      chk("spurious_ack_idle", 32'(halted), 1);

      base = fetch_t.size();
      foreach (imem[i]) if (i <= 3) exp_pc.push_back(i);
      run_prog("t1");
      rchk("t1_r1", 1, 16'd5);
      rchk("t1_r2", 2, 16'd3);
      rchk("t1_r3", 3, 16'd8);
      for (int i = 0; i < 3; i++) dchk("t1_alu_lat", base + i, 4);

      base = fetch_t.size();
      dwait = 3;
      for (int i = 4; i <= 8; i++) exp_pc.push_back(i);
      exp_we.push_back(1); exp_da.push_back(8'd4); exp_dw.push_back(16'd5);
      exp_we.push_back(0); exp_da.push_back(8'd4); exp_dw.push_back(16'd0);
      run_prog("t2");
      dwait = 0;
      rchk("t2_sub", 4, 16'hFFFE);
      rchk("t2_r0", 0, 16'h0);
      rchk("t2_ld", 5, 16'd5);
      chk("t2_dmem4", 32'(dmem[4]), 5);
      dchk("t2_sub_lat", base, 4);
      dchk("t2_li_lat", base + 1, 4);
      dchk("t2_st_lat", base + 2, 7);
      dchk("t2_ld_lat", base + 3, 8);

      base = fetch_t.size();
      exp_pc.push_back(9);
      repeat (3) exp_pc.push_back(10);
      pulse_run();
      for (int i = 0; i < 200 && exp_pc.size() != 0; i++) @(negedge clk);
      chk("t3_loop_fetches_left", exp_pc.size(), 0);
      iwait = 1000;
      exp_pc.push_back(10);
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         #1;
         if (imem_req && exp_pc.size() == 0) break;
      end
      chk("t3_stalled_req", 32'(imem_req), 1);
      dchk("t3_nop_lat", base, 3);
      dchk("t3_beq_lat", base + 1, 3);
      dchk("t3_beq_lat2", base + 2, 3);
      rst_n = 0;
      #1;
      chk("arst_imem_req", 32'(imem_req), 0);
      chk("arst_halted", 32'(halted), 1);
      for (int r = 0; r < 8; r++) rchk("arst_reg", r, 16'h0);
      @(negedge clk);
      rst_n = 1;
      iwait = 0;

      imem[0] = 16'hF000;  // HALT
      imem[1] = 16'h8205;  // LI r1,5
      imem[2] = 16'hD249;  // illegal opcode D
      imem[3] = 16'hCFFF;  // JMP 0xFFF
      imem[4095] = 16'h0000;
      exp_pc.push_back(0);
      run_prog("t4a");
      base = fetch_t.size();
      ill0 = ill_cnt;
      exp_pc.push_back(1); exp_pc.push_back(2); exp_pc.push_back(3);
      exp_pc.push_back(4095); exp_pc.push_back(0);
      run_prog("t4b");
      chk("t4_illegal_cycles", ill_cnt - ill0, 1);
      rchk("t4_r1", 1, 16'd5);
      rchk("t4_r2", 2, 16'd0);
      dchk("t4_li_lat", base, 4);
      dchk("t4_ill_lat", base + 1, 3);
      dchk("t4_jmp_lat", base + 2, 3);
      dchk("t4_nop_wrap_lat", base + 3, 3);

      chk("fetch_queue_drained", exp_pc.size(), 0);
      chk("dmem_queue_drained", exp_we.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
